// File: rtl/ece178_pio_in_capture.sv
// Avalon-MM input PIO: synchronises in_port, exposes its level, latches edges in a W1C capture register, masked IRQ.
// Optional per-bit debounce in front of the level register is compiled in with `define ECE178_PIO_DEBOUNCE_EN.
module ece178_pio_in_capture #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  // Bus handshake: zero-wait-state slave. A write takes effect at the clock edge where
  // chipselect=1 and write_n=0; readdata is a pure function of address and the registers,
  // valid in the same cycle, with no side effects and no dependence on chipselect.

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] lvl;
  logic [WIDTH-1:0] lvl_next;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] cap;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr_bits;
  logic             wr2;
  logic             wr3;
  logic             unused_wd;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef ECE178_PIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] db_cnt      [WIDTH];
  logic [CNT_W-1:0] db_cnt_next [WIDTH];

  // The level follows s only after s has differed from it for DEBOUNCE_CYCLES clocks in a row.
  always_comb begin
    lvl_next = lvl;
    for (int b = 0; b < WIDTH; b++) begin
      db_cnt_next[b] = '0;
      if (s[b] != lvl[b]) begin
        if (db_cnt[b] == CNT_LAST) begin
          lvl_next[b] = s[b];
        end else begin
          db_cnt_next[b] = db_cnt[b] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < WIDTH; b++) db_cnt[b] <= '0;
    end else begin
      for (int b = 0; b < WIDTH; b++) db_cnt[b] <= db_cnt_next[b];
    end
  end
`else
  assign lvl_next = s;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lvl  <= '0;
      prev <= '0;
    end else begin
      lvl  <= lvl_next;
      prev <= lvl;
    end
  end

  assign rise = lvl & ~prev;
  assign fall = ~lvl & prev;

  always_comb begin
    case (EDGE_TYPE)
      0:       edge_det = rise;
      1:       edge_det = fall;
      default: edge_det = rise | fall;
    endcase
  end

  assign wr2      = chipselect & ~write_n & (address == 2'd2);
  assign wr3      = chipselect & ~write_n & (address == 2'd3);
  assign clr_bits = wr3 ? writedata[WIDTH-1:0] : '0;

  // A new edge always wins over a simultaneous clear so no event is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap  <= '0;
      mask <= '0;
    end else begin
      cap <= edge_det | (cap & ~clr_bits);
      if (wr2) mask <= writedata[WIDTH-1:0];
    end
  end

  assign irq = |(cap & mask);

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = lvl;
      2'd2:    readdata[WIDTH-1:0] = mask;
      2'd3:    readdata[WIDTH-1:0] = cap;
      default: readdata = '0;
    endcase
  end

  assign unused_wd = ^{writedata, 1'b0};

endmodule

// File: tb/tb_ece178_pio_in_capture.sv
// Bench for ece178_pio_in_capture (default build): rising-edge and any-edge instances share one bus,
// a history-based reference model predicts reads and irq, a monitor pops expected reads from a queue.
module tb_ece178_pio_in_capture;

  localparam int WIDTH = 4;
  localparam int SS    = 2;

  logic             clk;
  logic             reset_n;
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [WIDTH-1:0] in_port;
  logic [31:0]      readdata_r;
  logic [31:0]      readdata_a;
  logic             irq_r;
  logic             irq_a;
  logic             rd_valid;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] exp_q [$];

  ece178_pio_in_capture #(.WIDTH(WIDTH), .SYNC_STAGES(SS), .EDGE_TYPE(0)) dut_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata_r),
    .in_port(in_port), .irq(irq_r)
  );

  ece178_pio_in_capture #(.WIDTH(WIDTH), .SYNC_STAGES(SS), .EDGE_TYPE(2)) dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata_a),
    .in_port(in_port), .irq(irq_a)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // hist[k] = in_port value sampled k edges ago; the level seen by software lags by SS edges.
  logic [WIDTH-1:0] hist [SS+2];
  logic [WIDTH-1:0] m_mask;
  logic [WIDTH-1:0] m_cap_r;
  logic [WIDTH-1:0] m_cap_a;

  always @(posedge clk or negedge reset_n) begin : model
    logic [WIDTH-1:0] lv, pv, rise, fall, clr;
    if (!reset_n) begin
      for (int i = 0; i < SS + 2; i++) hist[i] <= '0;
      m_mask  <= '0;
      m_cap_r <= '0;
      m_cap_a <= '0;
    end else begin
      lv   = hist[SS];
      pv   = hist[SS+1];
      rise = lv & ~pv;
      fall = pv & ~lv;
      clr  = (chipselect && !write_n && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
      m_cap_r <= rise | (m_cap_r & ~clr);
      m_cap_a <= rise | fall | (m_cap_a & ~clr);
      if (chipselect && !write_n && address == 2'd2) m_mask <= writedata[WIDTH-1:0];
      for (int i = SS + 1; i > 0; i--) hist[i] <= hist[i-1];
      hist[0] <= in_port;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [1:0] a, input logic any);
    logic [31:0] v;
    v = '0;
    case (a)
      2'd0:    v[WIDTH-1:0] = hist[SS];
      2'd2:    v[WIDTH-1:0] = m_mask;
      2'd3:    v[WIDTH-1:0] = any ? m_cap_a : m_cap_r;
      default: v = '0;
    endcase
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = '0;
    rd_valid   = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] a);
    chipselect = 1'($urandom_range(0, 1));
    write_n    = 1'b1;
    address    = a;
    writedata  = $urandom;
    rd_valid   = 1'b1;
    exp_q.push_back({exp_rd(a, 1'b0), exp_rd(a, 1'b1)});
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    rd_valid   = 1'b0;
  endtask

  task automatic read_all();
    for (int a = 0; a < 4; a++) begin
      do_read(2'(a));
      tick();
    end
    bus_idle();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [63:0] e;
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        check("read_no_expect", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rd_rise", readdata_r, e[63:32]);
        check("rd_any", readdata_a, e[31:0]);
      end
    end
    check("irq_rise", {31'd0, irq_r}, {31'd0, |(m_cap_r & m_mask)});
    check("irq_any", {31'd0, irq_a}, {31'd0, |(m_cap_a & m_mask)});
  end

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    in_port = 4'hF;
    bus_idle();
    tick();
    // Reads during reset must return zero.
    read_all();
    #2 reset_n = 1'b1;
    repeat (SS + 3) tick();
    // Inputs high at release: level F, rise captured, irq low with mask 0.
    read_all();

    // Rising edge on bit 2 with mask 4, then W1C.
    in_port = 4'h0;
    repeat (SS + 3) tick();
    do_write(2'd3, 32'hF);   tick();
    do_write(2'd2, 32'h4);   tick();
    bus_idle();
    in_port[2] = 1'b1;
    repeat (SS + 1) tick();
    do_read(2'd3);           tick();
    do_write(2'd3, 32'h4);   tick();
    do_read(2'd3);           tick();
    bus_idle();

    // Clear of bit 0 in the very cycle its rising edge is detected.
    do_write(2'd2, 32'h1);   tick();
    bus_idle();
    in_port[0] = 1'b1;
    repeat (SS + 1) tick();
    do_write(2'd3, 32'h1);   tick();
    do_read(2'd3);           tick();
    bus_idle();
    tick();

    // Bit 1 pulse of 5 clocks with mask 0; W1C between the two edges.
    do_write(2'd2, 32'h0);   tick();
    do_write(2'd3, 32'hF);   tick();
    bus_idle();
    in_port[1] = 1'b1;
    repeat (5) tick();
    in_port[1] = 1'b0;
    do_read(2'd3);           tick();
    do_write(2'd3, 32'h2);   tick();
    repeat (SS + 2) tick();
    do_read(2'd3);           tick();
    do_read(2'd0);           tick();
    bus_idle();

    // Randomized phase with one asynchronous reset in the middle.
    for (int c = 0; c < 1500; c++) begin
      int op;
      if ($urandom_range(0, 3) == 0) in_port[$urandom_range(0, WIDTH-1)] ^= 1'b1;
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2, 3, 4: do_read(2'($urandom_range(0, 3)));
        5: do_write(2'd2, $urandom);
        6: do_write(2'd3, $urandom);
        7: do_write(2'($urandom_range(0, 1)), $urandom);
        8: begin
          bus_idle();
          write_n   = 1'b0;
          address   = 2'($urandom_range(2, 3));
          writedata = $urandom;
        end
        default: bus_idle();
      endcase
      tick();
      if (c == 700) begin
        bus_idle();
        tick();
        #2 reset_n = 1'b0;
        tick();
        read_all();
        #2 reset_n = 1'b1;
      end
    end
    bus_idle();
    repeat (4) tick();

    check("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
